// File: rtl/uart_pattern_gen_if.sv
// uart_pattern_gen_if: character/handshake bus between the pattern generator and a UART transmitter
interface uart_pattern_gen_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] data;
    logic             send;
    logic             busy;
    modport master (output data, send, input busy);
    modport slave  (input data, send, output busy);
endinterface

// File: rtl/uart_pattern_gen.sv
// uart_pattern_gen: feeds a UART transmitter a repeating character pattern, one send pulse per character
module uart_pattern_gen #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] FIRST_CHAR  = 8'h30,
    parameter logic [WIDTH-1:0] LAST_CHAR   = 8'h39,
    parameter int               GAP_CYCLES  = 0,
    parameter int               ACK_TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        mode,
    uart_pattern_gen_if.master tx,
    output logic [15:0]       chars_sent,
    output logic              ack_err,
    output logic              active
);
    localparam int GW = $clog2(GAP_CYCLES + 2);
    localparam int TW = $clog2(ACK_TIMEOUT + 2);
    localparam logic [WIDTH-1:0] CR = WIDTH'(8'h0D);
    localparam logic [WIDTH-1:0] LF = WIDTH'(8'h0A);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE, GAP} state_t;

    state_t           state, nxt;
    logic [WIDTH-1:0] data, nxt_char;
    logic [GW-1:0]    gcnt;
    logic [TW-1:0]    tcnt;
    logic [15:0]      count;
    logic             armed, in_range, ack_expired, gap_done, done;

    assign tx.data     = data;
    assign tx.send     = state == SEND;
    assign active      = state != IDLE;
    assign chars_sent  = count;
    assign in_range    = data >= FIRST_CHAR && data <= LAST_CHAR;
    assign ack_expired = tcnt == TW'(ACK_TIMEOUT - 1);
    assign gap_done    = GAP_CYCLES <= 1 || gcnt == GW'(GAP_CYCLES - 1);
    assign done        = state == WAIT_DONE && !tx.busy;

    // Out-of-range data (e.g. CR/LF left over from mode 3) restarts the sequence at its natural start.
    assign nxt_char = mode == 2'd1 ? (in_range && data != FIRST_CHAR ? data - WIDTH'(1) : LAST_CHAR)
                    : mode == 2'd3 && data == CR ? LF
                    : mode != 2'd2 && in_range && data != LAST_CHAR ? data + WIDTH'(1)
                    : mode == 2'd3 && data == LAST_CHAR ? CR
                    : FIRST_CHAR;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:      nxt = enable && !tx.busy && armed ? SEND : IDLE;
            SEND:      nxt = WAIT_ACK;
            WAIT_ACK:  nxt = tx.busy ? WAIT_DONE : ack_expired ? GAP : WAIT_ACK;
            WAIT_DONE: nxt = tx.busy ? WAIT_DONE : GAP_CYCLES > 0 ? GAP : IDLE;
            GAP:       nxt = gap_done ? IDLE : GAP;
            default:   nxt = IDLE;
        endcase
    end

    // armed holds off the first send until the second clock after reset release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            data    <= FIRST_CHAR;
            count   <= '0;
            ack_err <= 1'b0;
            gcnt    <= '0;
            tcnt    <= '0;
            armed   <= 1'b0;
        end else begin
            state <= nxt;
            armed <= 1'b1;
            tcnt  <= state == WAIT_ACK ? tcnt + 1'b1 : '0;
            gcnt  <= state == GAP ? gcnt + 1'b1 : '0;
            if (state == WAIT_ACK && nxt == GAP)
                ack_err <= 1'b1;
            if (done) begin
                count <= count + 16'd1;
                data  <= nxt_char;
            end
        end
    end
endmodule

// File: tb/tb_uart_pattern_gen.sv
// tb_uart_pattern_gen: directed checks of pattern sequencing, handshake timing, gap, timeout and wrap
module tb_uart_pattern_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset0 = 1'b0, reset1 = 1'b0, en0 = 1'b0, en1 = 1'b0;
    logic        tx_on = 1'b1, mdl_busy = 1'b0, busy1 = 1'b0;
    logic [1:0]  mode0 = 2'd0, mode1 = 2'd0;
    logic [15:0] cnt0, cnt1;
    logic        err0, err1, act0, act1;
    int          n_chk = 0, n_fail = 0;
    logic [7:0]  sq[$];

    uart_pattern_gen_if #(.WIDTH(8)) bus0();
    uart_pattern_gen_if #(.WIDTH(8)) bus1();
    assign bus0.busy = tx_on ? mdl_busy : 1'b0;
    assign bus1.busy = busy1;

    uart_pattern_gen #(.GAP_CYCLES(0), .ACK_TIMEOUT(15)) dut0 (
        .clk(clk), .reset(reset0), .enable(en0), .mode(mode0), .tx(bus0.master),
        .chars_sent(cnt0), .ack_err(err0), .active(act0));

    uart_pattern_gen #(.GAP_CYCLES(5), .ACK_TIMEOUT(15)) dut1 (
        .clk(clk), .reset(reset1), .enable(en1), .mode(mode1), .tx(bus1.master),
        .chars_sent(cnt1), .ack_err(err1), .active(act1));

    // transmitter: busy rises one cycle after send and stays high for 10 cycles
    initial forever begin
        @(posedge clk); #1;
        if (bus0.send) begin
            @(posedge clk); #1 mdl_busy = 1'b1;
            repeat (10) @(posedge clk);
            #1 mdl_busy = 1'b0;
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (bus0.send) sq.push_back(bus0.data);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait0(input logic [15:0] target);
        for (int i = 0; i < 400 && cnt0 != target; i++) step();
        chk("wait chars_sent0", cnt0, target);
    endtask

    initial begin
        en0 = 1'b1;
        step(2);
        chk("rst data", bus0.data, 8'h30);
        chk("rst send", bus0.send, 0);
        chk("rst chars_sent", cnt0, 0);
        chk("rst ack_err", err0, 0);
        chk("rst active", act0, 0);
        chk("rst active1", act1, 0);
        reset0 = 1'b1;
        reset1 = 1'b1;
        step();
        chk("no send 1st edge", bus0.send, 0);
        step();
        chk("send 2nd edge", bus0.send, 1);
        chk("first char", bus0.data, 8'h30);
        // mode 0 ascending with wrap
        wait0(11);
        chk("m0 send count", sq.size(), 11);
        for (int i = 0; i < 11; i++) chk("m0 seq", sq[i], 8'h30 + 8'(i % 10));
        chk("m0 next data", bus0.data, 8'h31);
        // async reset during WAIT_ACK
        step();
        chk("send before rst", bus0.send, 1);
        step();
        chk("wait_ack active", act0, 1);
        chk("wait_ack send", bus0.send, 0);
        reset0 = 1'b0;
        mode0 = 2'd3;
        #1;
        chk("async rst send", bus0.send, 0);
        chk("async rst data", bus0.data, 8'h30);
        chk("async rst count", cnt0, 0);
        chk("async rst active", act0, 0);
        step();
        reset0 = 1'b1;
        sq.delete();
        // mode 3 with CR/LF, then mode 1 from LF
        wait0(11);
        chk("m3 data LF", bus0.data, 8'h0A);
        mode0 = 2'd1;
        wait0(13);
        chk("m3 send count", sq.size(), 13);
        chk("m3 first after rst", sq[0], 8'h30);
        chk("m3 last digit", sq[9], 8'h39);
        chk("m3 CR", sq[10], 8'h0D);
        chk("m3 LF", sq[11], 8'h0A);
        chk("m1 after LF", sq[12], 8'h39);
        chk("m1 next data", bus0.data, 8'h38);
        // enable dropped during WAIT_DONE
        step();
        chk("drop send", bus0.send, 1);
        chk("drop data", bus0.data, 8'h38);
        step(2);
        en0 = 1'b0;
        chk("drop active", act0, 1);
        wait0(14);
        step(30);
        chk("drop no more sends", sq.size(), 14);
        chk("drop count", cnt0, 14);
        chk("drop data next", bus0.data, 8'h37);
        chk("drop idle", act0, 0);
        // ack timeout with busy held low
        tx_on = 1'b0;
        sq.delete();
        en0 = 1'b1;
        step();
        chk("to send", bus0.send, 1);
        step(15);
        chk("to err early", err0, 0);
        step();
        chk("to err set", err0, 1);
        chk("to count held", cnt0, 14);
        chk("to data held", bus0.data, 8'h37);
        for (int i = 0; i < 10 && !bus0.send; i++) step();
        chk("to resend", bus0.send, 1);
        chk("to resend data", bus0.data, 8'h37);
        en0 = 1'b0;
        step(20);
        chk("to err sticky", err0, 1);
        chk("to count final", cnt0, 14);
        // GAP_CYCLES = 5
        en1 = 1'b1;
        step();
        chk("gap send", bus1.send, 1);
        busy1 = 1'b1;
        step(2);
        busy1 = 1'b0;
        step();
        chk("gap count", cnt1, 1);
        chk("gap data", bus1.data, 8'h31);
        for (int i = 0; i < 5; i++) begin
            chk("gap no send", bus1.send, 0);
            chk("gap active", act1, 1);
            step();
        end
        chk("gap idle send", bus1.send, 0);
        chk("gap idle", act1, 0);
        step();
        chk("gap resend", bus1.send, 1);
        // chars_sent wrap
        en1 = 1'b0;
        force dut1.count = 16'hFFFF;
        busy1 = 1'b1;
        #1 release dut1.count;
        step(2);
        busy1 = 1'b0;
        step();
        chk("wrap count", cnt1, 0);
        chk("wrap data", bus1.data, 8'h32);
        chk("wrap no err", err1, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_pattern_gen.md
UART_PATTERN_GEN -- requirements
Module: uart_pattern_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the character width.
REQ-002 SHALL have parameter FIRST_CHAR, default 8'h30, giving the first character of the pattern range.
REQ-003 SHALL have parameter LAST_CHAR, default 8'h39, giving the last character of the range; LAST_CHAR >= FIRST_CHAR.
REQ-004 SHALL have parameter GAP_CYCLES, default 0, giving the idle clocks inserted after each character completes (0 means none).
REQ-005 SHALL have parameter ACK_TIMEOUT, default 1023, giving the max clocks to wait for busy to rise after send.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port enable, input, 1 bit: while high, characters are generated continuously.
REQ-009 SHALL have port mode, input, 2 bits: pattern select (0 ascending, 1 descending, 2 fixed, 3 ascending+CR/LF).
REQ-010 SHALL have port busy, input, 1 bit: transmitter busy flag.
REQ-011 SHALL have port data, output, WIDTH bits: character presented to the transmitter.
REQ-012 SHALL have port send, output, 1 bit: one-cycle transmit request.
REQ-013 SHALL have port chars_sent, output, 16 bits: count of completed characters.
REQ-014 SHALL have port ack_err, output, 1 bit: sticky flag set when an ACK_TIMEOUT expires.
REQ-015 SHALL have port active, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, SEND, WAIT_ACK, WAIT_DONE and GAP.
REQ-017 SHALL move IDLE->SEND on the clock where enable=1 and busy=0; otherwise it stays in IDLE.
REQ-018 SHALL assert send for exactly the one cycle in SEND and move to WAIT_ACK; send SHALL be 0 in every other state.
REQ-019 SHALL, in WAIT_ACK, move to WAIT_DONE when busy=1; if busy has not risen after ACK_TIMEOUT cycles, it SHALL set ack_err and move to GAP without incrementing chars_sent.
REQ-020 SHALL, in WAIT_DONE, wait for busy=0, then increment chars_sent (16-bit, wrapping FFFF->0000), update data to the next character, and go to GAP when GAP_CYCLES>0 or else to IDLE.
REQ-021 SHALL, in GAP, count GAP_CYCLES clocks and then move to IDLE.
REQ-022 SHALL hold data stable from SEND through WAIT_DONE; it changes only on the WAIT_DONE exit cycle.
REQ-023 SHALL apply this next-character rule for mode 0: data+1, with LAST_CHAR wrapping to FIRST_CHAR.
REQ-024 SHALL apply this next-character rule for mode 1: data-1, with FIRST_CHAR wrapping to LAST_CHAR.
REQ-025 SHALL apply this next-character rule for mode 2: data = FIRST_CHAR always.
REQ-026 SHALL apply this next-character rule for mode 3: sequence FIRST..LAST, then 8'h0D, then 8'h0A, then FIRST_CHAR.
REQ-027 SHALL, when data is outside [FIRST_CHAR, LAST_CHAR] (e.g. CR/LF after a mode change), make the next character FIRST_CHAR in modes 0/2/3 (mode 3 only when data is not 8'h0D) and LAST_CHAR in mode 1.
REQ-028 SHALL sample mode only at the WAIT_DONE exit; a mode change mid-character does not affect the current character.
REQ-029 SHALL, when enable falls mid-character, finish the character (including the GAP) and then stay in IDLE; there is no abort.
REQ-030 SHALL, when busy is already high in IDLE (external user), not issue send until busy=0.
REQ-031 SHALL keep ack_err high until reset.

Reset
REQ-032 SHALL, while reset=0, immediately (asynchronously) force state=IDLE, data=FIRST_CHAR, send=0, chars_sent=0, ack_err=0, active=0, and gap/timeout counters=0.
REQ-033 SHALL, on reset assertion mid-character, drop send in the same instant, and the first character after release SHALL be FIRST_CHAR.
REQ-034 SHALL allow the first SEND no earlier than the second rising clk edge after reset deasserts.

Verification
REQ-035 SHALL cover: mode 0, GAP_CYCLES=0, with a transmitter model (busy high 10 cycles, 1 cycle after send) -> data sequence 30,31..39,30; exactly one send per char; chars_sent=11 after 11 chars.
REQ-036 SHALL cover: mode 3 -> sequence 30..39,0D,0A,30; then switch to mode 1 while data=0A -> next char 39, then 38.
REQ-037 SHALL cover: GAP_CYCLES=5 -> exactly 5 idle clocks between busy fall and the next send pulse (plus 1 IDLE cycle).
REQ-038 SHALL cover: busy held low with ACK_TIMEOUT=15 -> ack_err=1 after 15 WAIT_ACK cycles, chars_sent unchanged, data advances by 0, and send repeats.
REQ-039 SHALL cover: enable dropped during WAIT_DONE -> the character completes, chars_sent increments once, and there are no further sends; reset asserted during WAIT_ACK -> send=0, data=30, chars_sent=0 immediately.
REQ-040 SHALL cover: chars_sent preloaded via 65535 completions (or forced) -> the next completion wraps it to 0.
